pipeline_controller: RTL and testbench
======================================

// Module: pipeline_controller
// PURPOSE
//  Hazard/control unit driving the ControllerIF Controller modport. Each cycle it produces
//  per-stage stall/flush controls, the redirect PC (irregPc) and forwarded execute operands.
//  - sits beside the 5-stage pipe: fetch -> decode -> execute -> memoryAccess -> writeback
//  - handles branch mispredict redirects, load-use interlocks, multi-cycle memory waits and
//    operand bypass from memoryAccess/writeback
// PARAMETERS
//  MEM_TIMEOUT    256  memory-wait cycles before memTimeout sets (sticky)
//  CNT_WIDTH      32   width of stallCycles counter
// PORTS
//  clk                in   1    clock
//  rst                in   1    synchronous active-high reset
//  exRs1Addr/exRs2Addr in  5    source regs of instruction in execute
//  exRs1Used/exRs2Used in  1    source actually read
//  exRs1Data/exRs2Data in  32   register-file values latched for execute
//  exBrMiss           in   1    execute resolved a mispredicted branch/jump
//  exBrTarget         in   32   correct PC for exBrMiss
//  maRd / maWrEn      in   5/1  memoryAccess destination, write enable
//  maIsLoad           in   1    memoryAccess instruction is a load
//  maResult           in   32   memoryAccess ALU result (non-load)
//  maReq / maAck      in   1/1  data-memory request issued / completed this cycle
//  wbRd / wbWrEn      in   5/1  writeback destination, write enable
//  wbResult           in   32   writeback data
//  irregPc            out  32   redirect PC, valid when fetchStage.flush
//  bypassedRs1/2      out  32   forwarded operands for execute
//  fetchStage, decodeStage, executeStage, memoryAccessStage  out StageCtrl  {stall,flush}
//  fetchStageVirtual  out  StageCtrl  fetchStage delayed one cycle (imem latency)
//  memTimeout         out  1    sticky: memory wait exceeded MEM_TIMEOUT
//  stallCycles        out  CNT_WIDTH  saturating count of cycles any stage stalled
// BEHAVIOUR
//  - StageCtrl of stage X governs X's output pipeline register:
//    stall = hold; flush = load bubble; stall wins over flush.
//  - Reset: all StageCtrl = {0,0}; fetchStageVirtual = {0,0}; irregPc = 0;
//    memTimeout = 0; stallCycles = 0; FSM = RUN; waitCnt = 0.
//  - FSM RUN:
//    maReq && !maAck -> MEM_WAIT; in that same cycle all four stages stall.
//  - FSM MEM_WAIT:
//    all stages stall; waitCnt++; waitCnt == MEM_TIMEOUT-1 sets memTimeout.
//    maAck -> RUN with waitCnt = 0; the ack cycle itself is not stalled.
//    exBrMiss is ignored while waiting; it is re-evaluated after return to RUN (branch held in execute).
//  - Priority in RUN: memory wait > exBrMiss > load-use.
//  - exBrMiss:
//    fetch.flush = decode.flush = 1; irregPc = exBrTarget combinationally.
//    execute/memoryAccess proceed.
//    Next cycle fetchStageVirtual.flush = 1, so decode squashes the returning imem word.
//  - Load-use:
//    (exRsN == maRd) && maWrEn && maIsLoad && exRsNUsed && maRd != 0
//    -> fetch, decode and execute stall; memoryAccess.flush = 1 (bubble).
//    One cycle later the load is in writeback and is forwarded.
//  - Bypass per operand (combinational):
//    maWrEn && !maIsLoad && maRd == rs && rs != 0 -> maResult;
//    else wbWrEn && wbRd == rs && rs != 0 -> wbResult;
//    else exRsNData. x0 is never forwarded.
//  - fetchStageVirtual: register of fetchStage; holds its value while fetchStage.stall.
//  - stallCycles: +1 on any cycle with any stall = 1; saturates at all-ones.
//  - Reset mid-wait/mid-redirect:
//    returns to RUN next edge; pending redirect is dropped; memTimeout is cleared.
// STRUCTURE
//  - ControllerTypes package:
//    StageCtrl struct {stall, flush}; ControllerState enum {RUN, MEM_WAIT}; RegAddr (5b).
//  - BasicTypes: BasicData (32), PC (32).
//  - Sub-module bypass_unit (one instance per operand): pure forwarding mux.
//  - FSM, interlock and counters live in the top module.
//  - Top exposes the ControllerIF.Controller modport.
// TESTING
//  1. rst held 2 cycles with exBrMiss=1, maReq=1 -> all outputs 0, stallCycles=0 after release.
//  2. exBrMiss=1, exBrTarget=0x0000_0100
//     -> same cycle fetch/decode flush=1, irregPc=0x100; next cycle fetchStageVirtual.flush=1.
//  3. maRd=5 load, exRs1Addr=5 used
//     -> fetch/decode/execute stall 1 cycle, memoryAccess flush;
//     next cycle wbRd=5, wbResult=0xDEAD -> bypassedRs1=0xDEAD.
//  4. maReq=1, maAck low 3 cycles then high
//     -> all stall 3 cycles, stallCycles=3, FSM RUN on the ack cycle.
//  5. MEM_TIMEOUT=4, maAck never high
//     -> memTimeout=1 after 4 wait cycles, stays set until rst.
//  6. maRd=wbRd=7 non-load, maResult=1, wbResult=2 -> bypass=1;
//     rs=0 with maRd=0 -> bypass=exRsData.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// Shared types for the pipeline hazard/control unit: stage control word, FSM states,
// register/data/PC types and the common "destination matches source" test.
package pipeline_controller_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] basic_data_t;
    typedef logic [31:0] pc_t;

    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctrl_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_e;

    // A writer hits a source only when it actually writes and the source is not x0.
    function automatic logic addr_hit(input logic wr_en, input reg_addr_t rd, input reg_addr_t rs);
        return wr_en && (rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/pipeline_controller_bypass_unit.sv
// Forwarding mux for one execute operand: memoryAccess result beats writeback result,
// which beats the register-file value. Loads in memoryAccess are not yet forwardable.
module bypass_unit
    import pipeline_controller_pkg::*;
(
    input  logic [4:0]  i_rs_addr,
    input  logic [31:0] i_rs_data,
    input  logic [4:0]  i_ma_rd,
    input  logic        i_ma_wr_en,
    input  logic        i_ma_is_load,
    input  logic [31:0] i_ma_result,
    input  logic [4:0]  i_wb_rd,
    input  logic        i_wb_wr_en,
    input  logic [31:0] i_wb_result,
    output logic [31:0] o_data
);

    logic w_ma_hit;
    logic w_wb_hit;

    assign w_ma_hit = addr_hit(i_ma_wr_en && !i_ma_is_load, i_ma_rd, i_rs_addr);
    assign w_wb_hit = addr_hit(i_wb_wr_en, i_wb_rd, i_rs_addr);

    assign o_data = w_ma_hit ? i_ma_result :
                    w_wb_hit ? i_wb_result : i_rs_data;

endmodule

// File: rtl/pipeline_controller.sv
// Hazard/control unit for the 5-stage pipe: memory-wait FSM, branch redirect,
// load-use interlock, operand bypass, fetch-control delay line and stall statistics.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           i_ex_rs1_addr,
    input  logic [4:0]           i_ex_rs2_addr,
    input  logic                 i_ex_rs1_used,
    input  logic                 i_ex_rs2_used,
    input  logic [31:0]          i_ex_rs1_data,
    input  logic [31:0]          i_ex_rs2_data,
    input  logic                 i_ex_br_miss,
    input  logic [31:0]          i_ex_br_target,
    input  logic [4:0]           i_ma_rd,
    input  logic                 i_ma_wr_en,
    input  logic                 i_ma_is_load,
    input  logic [31:0]          i_ma_result,
    input  logic                 i_ma_req,
    input  logic                 i_ma_ack,
    input  logic [4:0]           i_wb_rd,
    input  logic                 i_wb_wr_en,
    input  logic [31:0]          i_wb_result,
    output logic [31:0]          o_irreg_pc,
    output logic [31:0]          o_bypassed_rs1,
    output logic [31:0]          o_bypassed_rs2,
    output logic                 o_fetch_stall,
    output logic                 o_fetch_flush,
    output logic                 o_decode_stall,
    output logic                 o_decode_flush,
    output logic                 o_execute_stall,
    output logic                 o_execute_flush,
    output logic                 o_mem_access_stall,
    output logic                 o_mem_access_flush,
    output logic                 o_fetch_virtual_stall,
    output logic                 o_fetch_virtual_flush,
    output logic                 o_mem_timeout,
    output logic [CNT_WIDTH-1:0] o_stall_cycles
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_e          r_state;
    logic [WAIT_W-1:0]    r_wait_cnt;
    logic                 r_mem_timeout;
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    stage_ctrl_t          r_fetch_virtual;

    stage_ctrl_t w_fetch;
    stage_ctrl_t w_decode;
    stage_ctrl_t w_execute;
    stage_ctrl_t w_mem_access;
    logic        w_mem_stall;
    logic        w_redirect;
    logic        w_load_use;
    logic        w_any_stall;
    pc_t         w_irreg_pc;

    bypass_unit u_bypass_rs1 (
        .i_rs_addr    (i_ex_rs1_addr),
        .i_rs_data    (i_ex_rs1_data),
        .i_ma_rd      (i_ma_rd),
        .i_ma_wr_en   (i_ma_wr_en),
        .i_ma_is_load (i_ma_is_load),
        .i_ma_result  (i_ma_result),
        .i_wb_rd      (i_wb_rd),
        .i_wb_wr_en   (i_wb_wr_en),
        .i_wb_result  (i_wb_result),
        .o_data       (o_bypassed_rs1)
    );

    bypass_unit u_bypass_rs2 (
        .i_rs_addr    (i_ex_rs2_addr),
        .i_rs_data    (i_ex_rs2_data),
        .i_ma_rd      (i_ma_rd),
        .i_ma_wr_en   (i_ma_wr_en),
        .i_ma_is_load (i_ma_is_load),
        .i_ma_result  (i_ma_result),
        .i_wb_rd      (i_wb_rd),
        .i_wb_wr_en   (i_wb_wr_en),
        .i_wb_result  (i_wb_result),
        .o_data       (o_bypassed_rs2)
    );

    // The ack cycle is not a wait cycle, so branch and load-use are judged normally there.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_fetch      = '0;
        w_decode     = '0;
        w_execute    = '0;
        w_mem_access = '0;
        w_irreg_pc   = '0;
        w_mem_stall  = 1'b0;
        w_redirect   = 1'b0;
        w_load_use   = 1'b0;
        if (!rst) begin
            w_mem_stall = !i_ma_ack && ((r_state == MEM_WAIT) || i_ma_req);
            w_redirect  = !w_mem_stall && i_ex_br_miss;
            w_load_use  = !w_mem_stall && !i_ex_br_miss &&
                          ((i_ex_rs1_used && addr_hit(i_ma_wr_en && i_ma_is_load, i_ma_rd, i_ex_rs1_addr)) ||
                           (i_ex_rs2_used && addr_hit(i_ma_wr_en && i_ma_is_load, i_ma_rd, i_ex_rs2_addr)));
            if (w_mem_stall) begin
                w_fetch.stall      = 1'b1;
                w_decode.stall     = 1'b1;
                w_execute.stall    = 1'b1;
                w_mem_access.stall = 1'b1;
            end else if (w_redirect) begin
                w_fetch.flush  = 1'b1;
                w_decode.flush = 1'b1;
                w_irreg_pc     = i_ex_br_target;
            end else if (w_load_use) begin
                w_fetch.stall      = 1'b1;
                w_decode.stall     = 1'b1;
                w_execute.stall    = 1'b1;
                w_mem_access.flush = 1'b1;
            end
        end
    end

    assign w_any_stall = w_fetch.stall | w_decode.stall | w_execute.stall | w_mem_access.stall;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            r_state         <= RUN;
            r_wait_cnt      <= '0;
            r_mem_timeout   <= 1'b0;
            r_stall_cycles  <= '0;
            r_fetch_virtual <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_ma_req && !i_ma_ack) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (i_ma_ack) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase
            if (w_any_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (!w_fetch.stall) begin
                r_fetch_virtual <= w_fetch;
            end
        end
    end

    assign o_irreg_pc            = w_irreg_pc;
    assign o_fetch_stall         = w_fetch.stall;
    assign o_fetch_flush         = w_fetch.flush;
    assign o_decode_stall        = w_decode.stall;
    assign o_decode_flush        = w_decode.flush;
    assign o_execute_stall       = w_execute.stall;
    assign o_execute_flush       = w_execute.flush;
    assign o_mem_access_stall    = w_mem_access.stall;
    assign o_mem_access_flush    = w_mem_access.flush;
    assign o_fetch_virtual_stall = r_fetch_virtual.stall;
    assign o_fetch_virtual_flush = r_fetch_virtual.flush;
    assign o_mem_timeout         = r_mem_timeout;
    assign o_stall_cycles        = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: a driver issues directed and random cycles and
// queues the reference model's expected outputs; a monitor pops and compares on the falling edge.
module tb_pipeline_controller;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct {
        bit          rst;
        bit [4:0]    rs1, rs2;
        bit          rs1_used, rs2_used;
        bit [31:0]   rs1_data, rs2_data;
        bit          br_miss;
        bit [31:0]   br_target;
        bit [4:0]    ma_rd;
        bit          ma_wr_en, ma_is_load;
        bit [31:0]   ma_result;
        bit          req, ack;
        bit [4:0]    wb_rd;
        bit          wb_wr_en;
        bit [31:0]   wb_result;
    } stim_t;

    typedef struct {
        int          cycle;
        bit [7:0]    ctrl;
        bit [1:0]    fv;
        bit [31:0]   irreg_pc;
        bit [31:0]   byp1, byp2;
        bit          timeout;
        int          stalls;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr;
    logic        ex_rs1_used, ex_rs2_used;
    logic [31:0] ex_rs1_data, ex_rs2_data;
    logic        ex_br_miss;
    logic [31:0] ex_br_target;
    logic [4:0]  ma_rd;
    logic        ma_wr_en, ma_is_load;
    logic [31:0] ma_result;
    logic        ma_req, ma_ack;
    logic [4:0]  wb_rd;
    logic        wb_wr_en;
    logic [31:0] wb_result;
    logic [31:0] irreg_pc, byp_rs1, byp_rs2;
    logic        f_stall, f_flush, d_stall, d_flush, e_stall, e_flush, m_stall, m_flush;
    logic        fv_stall, fv_flush, mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    pipeline_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_WIDTH(CNT_W)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_ex_rs1_addr         (ex_rs1_addr),
        .i_ex_rs2_addr         (ex_rs2_addr),
        .i_ex_rs1_used         (ex_rs1_used),
        .i_ex_rs2_used         (ex_rs2_used),
        .i_ex_rs1_data         (ex_rs1_data),
        .i_ex_rs2_data         (ex_rs2_data),
        .i_ex_br_miss          (ex_br_miss),
        .i_ex_br_target        (ex_br_target),
        .i_ma_rd               (ma_rd),
        .i_ma_wr_en            (ma_wr_en),
        .i_ma_is_load          (ma_is_load),
        .i_ma_result           (ma_result),
        .i_ma_req              (ma_req),
        .i_ma_ack              (ma_ack),
        .i_wb_rd               (wb_rd),
        .i_wb_wr_en            (wb_wr_en),
        .i_wb_result           (wb_result),
        .o_irreg_pc            (irreg_pc),
        .o_bypassed_rs1        (byp_rs1),
        .o_bypassed_rs2        (byp_rs2),
        .o_fetch_stall         (f_stall),
        .o_fetch_flush         (f_flush),
        .o_decode_stall        (d_stall),
        .o_decode_flush        (d_flush),
        .o_execute_stall       (e_stall),
        .o_execute_flush       (e_flush),
        .o_mem_access_stall    (m_stall),
        .o_mem_access_flush    (m_flush),
        .o_fetch_virtual_stall (fv_stall),
        .o_fetch_virtual_flush (fv_flush),
        .o_mem_timeout         (mem_timeout),
        .o_stall_cycles        (stall_cycles)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    bit   done     = 1'b0;
    exp_t exp_q[$];

    // Reference-model state, in the terms the behaviour is described in.
    bit m_waiting;
    int m_waited;
    bit m_timeout;
    int m_stalls;
    bit [1:0] m_fv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cycle, act, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic bit [31:0] fwd(input bit [4:0] rs, input bit [31:0] rf, input stim_t s);
        if (rs == 0) return rf;
        if (s.ma_wr_en && !s.ma_is_load && s.ma_rd == rs) return s.ma_result;
        if (s.wb_wr_en && s.wb_rd == rs) return s.wb_result;
        return rf;
    endfunction

    function automatic bit load_dep(input bit [4:0] rs, input bit used, input stim_t s);
        return used && rs != 0 && s.ma_wr_en && s.ma_is_load && s.ma_rd == rs;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        bit   busy;
        bit   any_stall;
        rst = s.rst;
        ex_rs1_addr = s.rs1;        ex_rs2_addr = s.rs2;
        ex_rs1_used = s.rs1_used;   ex_rs2_used = s.rs2_used;
        ex_rs1_data = s.rs1_data;   ex_rs2_data = s.rs2_data;
        ex_br_miss  = s.br_miss;    ex_br_target = s.br_target;
        ma_rd = s.ma_rd;  ma_wr_en = s.ma_wr_en;  ma_is_load = s.ma_is_load;
        ma_result = s.ma_result;  ma_req = s.req;  ma_ack = s.ack;
        wb_rd = s.wb_rd;  wb_wr_en = s.wb_wr_en;  wb_result = s.wb_result;

        e.cycle = cycle;
        e.ctrl = '0;
        e.irreg_pc = '0;
        if (!s.rst) begin
            busy = !s.ack && (m_waiting || s.req);
            if (busy)
                e.ctrl = 8'b1010_1010;
            else if (s.br_miss) begin
                e.ctrl = 8'b0101_0000;
                e.irreg_pc = s.br_target;
            end else if (load_dep(s.rs1, s.rs1_used, s) || load_dep(s.rs2, s.rs2_used, s))
                e.ctrl = 8'b1010_1001;
        end
        e.fv = m_fv;
        e.timeout = m_timeout;
        e.stalls = m_stalls;
        e.byp1 = fwd(s.rs1, s.rs1_data, s);
        e.byp2 = fwd(s.rs2, s.rs2_data, s);
        exp_q.push_back(e);

        if (s.rst) begin
            m_waiting = 0; m_waited = 0; m_timeout = 0; m_stalls = 0; m_fv = 2'b00;
        end else begin
            any_stall = e.ctrl[7] | e.ctrl[5] | e.ctrl[3] | e.ctrl[1];
            if (any_stall && m_stalls < CNT_MAX) m_stalls++;
            if (!e.ctrl[7]) m_fv = e.ctrl[7:6];
            if (m_waiting) begin
                if (s.ack) begin
                    m_waiting = 0;
                    m_waited = 0;
                end else begin
                    m_waited++;
                    if (m_waited >= MEM_TIMEOUT) m_timeout = 1;
                end
            end else if (s.req && !s.ack) begin
                m_waiting = 1;
                m_waited = 0;
            end
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stage_ctrl", {f_stall, f_flush, d_stall, d_flush, e_stall, e_flush, m_stall, m_flush}, e.ctrl);
                check("fetch_virtual", {fv_stall, fv_flush}, e.fv);
                check("irreg_pc", irreg_pc, e.irreg_pc);
                check("bypass_rs1", byp_rs1, e.byp1);
                check("bypass_rs2", byp_rs2, e.byp2);
                check("mem_timeout", mem_timeout, e.timeout);
                check("stall_cycles", stall_cycles, e.stalls);
            end
        end
    end

    initial begin : driver
        stim_t s;
        m_waiting = 0; m_waited = 0; m_timeout = 0; m_stalls = 0; m_fv = 2'b00;
        s = idle();
        s.rst = 1; s.br_miss = 1; s.br_target = 32'h40; s.req = 1;
        rst = 1; ex_br_miss = 1; ma_req = 1; ma_ack = 0;
        ex_rs1_addr = 0; ex_rs2_addr = 0; ex_rs1_used = 0; ex_rs2_used = 0;
        ex_rs1_data = 0; ex_rs2_data = 0; ex_br_target = 32'h40;
        ma_rd = 0; ma_wr_en = 0; ma_is_load = 0; ma_result = 0;
        wb_rd = 0; wb_wr_en = 0; wb_result = 0;
        @(posedge clk);
        #1;
        drive(s);                              // second reset cycle, branch+req asserted
        drive(idle());

        s = idle(); s.br_miss = 1; s.br_target = 32'h100;
        drive(s);
        drive(idle());                         // fetch-virtual flush appears here

        s = idle(); s.ma_rd = 5; s.ma_wr_en = 1; s.ma_is_load = 1;
        s.rs1 = 5; s.rs1_used = 1; s.rs1_data = 32'h1111;
        drive(s);
        s = idle(); s.wb_rd = 5; s.wb_wr_en = 1; s.wb_result = 32'hDEAD;
        s.rs1 = 5; s.rs1_used = 1; s.rs1_data = 32'h1111;
        drive(s);

        s = idle(); s.req = 1;
        repeat (3) drive(s);
        s.ack = 1;
        drive(s);
        s = idle(); s.br_miss = 1; s.br_target = 32'h2000;
        drive(s);                              // back in RUN: redirect honoured

        s = idle(); s.ma_rd = 7; s.wb_rd = 7; s.ma_wr_en = 1; s.wb_wr_en = 1;
        s.ma_result = 1; s.wb_result = 2; s.rs1 = 7; s.rs2 = 0; s.rs2_data = 32'h5A5A;
        drive(s);
        s.ma_rd = 0; s.rs1 = 0; s.rs1_data = 32'hA5A5;
        drive(s);

        s = idle(); s.req = 1;
        repeat (300) drive(s);                 // timeout and counter saturation
        s = idle(); s.br_miss = 1;
        drive(s);                              // still waiting: redirect ignored
        s = idle(); s.rst = 1; s.br_miss = 1;
        drive(s);
        drive(idle());

        repeat (1500) begin
            s = idle();
            s.rst = ($urandom_range(0, 299) == 0);
            s.rs1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3));
            s.rs1_used = 1'($urandom);
            s.rs2_used = 1'($urandom);
            s.rs1_data = $urandom;
            s.rs2_data = $urandom;
            s.br_miss = ($urandom_range(0, 5) == 0);
            s.br_target = $urandom;
            s.ma_rd = 5'($urandom_range(0, 3));
            s.ma_wr_en = 1'($urandom);
            s.ma_is_load = 1'($urandom);
            s.ma_result = $urandom;
            s.req = ($urandom_range(0, 7) == 0);
            s.ack = ($urandom_range(0, 2) == 0);
            s.wb_rd = 5'($urandom_range(0, 3));
            s.wb_wr_en = 1'($urandom);
            s.wb_result = $urandom;
            drive(s);
        end
        done = 1'b1;
    end

    initial begin : finisher
        wait (done);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=completion", cycle);
        $fatal(1, "bench did not complete");
    end

endmodule
